mul_div_unit: RTL

Iterative 32-bit multiply/divide unit for the MIPS datapath, executing MULT, MULTU, DIV and DIVU and holding the results in internal HI and LO registers. It sits directly downstream of the ID/EX operand registers, taking rs/rt values as A/B. It feeds the writeback path through its Hi/Lo outputs, which MFHI/MFLO read. The hazard logic stalls on Busy.

---
 rtl/mul_div_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Multiplies by radix-2 shift-add and divides by restoring division, one bit per cycle.
module mul_div_unit (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        MtHi,
   input  logic        MtLo,
   input  logic [31:0] WrData,
   output logic        Busy,
   output logic        Done,
   output logic        DivByZero,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction

   logic [1:0]  state_r;
   logic [4:0]  cnt_r;
   logic [1:0]  op_r;
   logic [31:0] a_r;
   logic [31:0] opnd_r;     // multiplicand magnitude or divisor magnitude
   logic [63:0] acc_r;      // product accumulator; low word doubles as dividend/quotient shifter
   logic [32:0] rem_r;
   logic        neg_r;
   logic        asign_r;
   logic        bzero_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;
   logic        busy_r;
   logic        done_r;
   logic        dbz_r;

   logic        start_signed_s;
   logic [31:0] start_amag_s;
   logic [31:0] start_bmag_s;
   logic [32:0] mul_sum_s;
   logic [63:0] mul_next_s;
   logic [33:0] div_trial_s;
   logic [32:0] div_diff_s;
   logic        div_ge_s;
   logic [32:0] div_rem_next_s;
   logic [31:0] div_q_next_s;
   logic [63:0] prod_fix_s;
   logic [31:0] quo_fix_s;
   logic [31:0] rem_fix_s;
   logic [31:0] fix_hi_s;
   logic [31:0] fix_lo_s;

   // Operand magnitudes for a launch and one shift-add / restoring-divide step.
   always_comb begin
      start_signed_s = ~Op[0];
      start_amag_s   = mag32(A, start_signed_s);
      start_bmag_s   = mag32(B, start_signed_s);

      mul_sum_s      = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
      mul_next_s     = {mul_sum_s, acc_r[31:1]};

      div_trial_s    = {rem_r, acc_r[31]};
      div_ge_s       = (div_trial_s >= {2'b00, opnd_r});
      div_diff_s     = div_trial_s[32:0] - {1'b0, opnd_r};
      if (div_ge_s) begin
         div_rem_next_s = div_diff_s;
      end else begin
         div_rem_next_s = div_trial_s[32:0];
      end
      div_q_next_s   = {acc_r[30:0], div_ge_s};
   end

   // Sign correction and divide-by-zero override applied in the FIX cycle.
   always_comb begin
      prod_fix_s = neg_r   ? neg64(acc_r)          : acc_r;
      quo_fix_s  = neg_r   ? neg32(acc_r[31:0])    : acc_r[31:0];
      rem_fix_s  = asign_r ? neg32(rem_r[31:0])    : rem_r[31:0];
      fix_hi_s   = prod_fix_s[63:32];
      fix_lo_s   = prod_fix_s[31:0];
      case (op_r)
         OP_MULT, OP_MULTU: begin
            fix_hi_s = prod_fix_s[63:32];
            fix_lo_s = prod_fix_s[31:0];
         end
         OP_DIV, OP_DIVU: begin
            if (bzero_r) begin
               fix_hi_s = a_r;
               fix_lo_s = 32'hFFFF_FFFF;
            end else begin
               fix_hi_s = rem_fix_s;
               fix_lo_s = quo_fix_s;
            end
         end
         default: begin
            fix_hi_s = prod_fix_s[63:32];
            fix_lo_s = prod_fix_s[31:0];
         end
      endcase
   end

   // Control FSM, iteration datapath and HI/LO registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 5'd0;
         op_r    <= 2'b00;
         a_r     <= 32'd0;
         opnd_r  <= 32'd0;
         acc_r   <= 64'd0;
         rem_r   <= 33'd0;
         neg_r   <= 1'b0;
         asign_r <= 1'b0;
         bzero_r <= 1'b0;
         hi_r    <= 32'd0;
         lo_r    <= 32'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         dbz_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (Start) begin
                  op_r    <= Op;
                  a_r     <= A;
                  neg_r   <= start_signed_s & (A[31] ^ B[31]);
                  asign_r <= start_signed_s & A[31];
                  bzero_r <= Op[1] & (B == 32'd0);
                  opnd_r  <= Op[1] ? start_bmag_s : start_amag_s;
                  acc_r   <= Op[1] ? {32'd0, start_amag_s} : {32'd0, start_bmag_s};
                  rem_r   <= 33'd0;
                  cnt_r   <= 5'd0;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  if (MtHi) begin
                     hi_r <= WrData;
                  end
                  if (MtLo) begin
                     lo_r <= WrData;
                  end
               end
            end
            ST_RUN: begin
               if (op_r[1]) begin
                  rem_r           <= div_rem_next_s;
                  acc_r[31:0]     <= div_q_next_s;
               end else begin
                  acc_r           <= mul_next_s;
               end
               cnt_r <= cnt_r + 5'd1;
               if (cnt_r == 5'd31) begin
                  state_r <= ST_FIX;
               end
            end
            ST_FIX: begin
               hi_r    <= fix_hi_s;
               lo_r    <= fix_lo_s;
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
               dbz_r   <= bzero_r;
               cnt_r   <= 5'd0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign Busy      = busy_r;
   assign Done      = done_r;
   assign DivByZero = dbz_r;
   assign Hi        = hi_r;
   assign Lo        = lo_r;

endmodule
